// File: rtl/gpu_ext_arbiter_pkg.sv
// Shared definitions for the GPU external-port arbiter: target encodings,
// FSM state type and the request rejection rule.
package gpu_ext_arbiter_pkg;

  localparam logic [2:0] TGT_INST_RAM  = 3'd0;
  localparam logic [2:0] TGT_DATA_RAM  = 3'd1;
  localparam logic [2:0] TGT_INT_REG   = 3'd2;
  localparam logic [2:0] TGT_FLOAT_REG = 3'd3;
  localparam logic [2:0] TGT_SPECIAL   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // Only the two RAMs accept writes; encodings above TGT_SPECIAL do not exist.
  function automatic logic is_reject(input logic write, input logic [2:0] target);
    return (target > TGT_SPECIAL) || (write && (target > TGT_DATA_RAM));
  endfunction

endpackage

// File: rtl/gpu_ext_arbiter_if.sv
// Bundle of requester-side and GPU-side signals of the external arbiter.
// Handshake: a requester raises req_valid[i] with its fields held stable;
// the request is taken on the rising edge where req_valid[i] && req_ready[i].
// The matching response is a one-cycle rsp_valid[i] pulse, with rsp_error
// and rsp_data meaningful only in that cycle.
interface gpu_ext_arbiter_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) ();
  import gpu_ext_arbiter_pkg::*;

  logic                          gpu_run;
  logic [1:0]                    req_valid;
  logic [1:0]                    req_ready;
  logic [1:0]                    req_write;
  logic [1:0][2:0]               req_target;
  logic [1:0][ADDRESS_WIDTH-1:0] req_address;
  logic [1:0][WORD_WIDTH-1:0]    req_wdata;
  logic [1:0]                    rsp_valid;
  logic                          rsp_error;
  logic [WORD_WIDTH-1:0]         rsp_data;
  logic                          enable_write_inst_ram;
  logic                          enable_write_data_ram;
  logic                          enable_read_inst_ram;
  logic                          enable_read_data_ram;
  logic                          enable_read_register;
  logic                          enable_read_floatreg;
  logic                          enable_read_special;
  logic [ADDRESS_WIDTH-1:0]      rw_address;
  logic [WORD_WIDTH-1:0]         write_data;
  logic [WORD_WIDTH-1:0]         read_data;
  state_t                        dbg_state;

  modport slave (
    input  gpu_run, req_valid, req_write, req_target, req_address, req_wdata, read_data,
    output req_ready, rsp_valid, rsp_error, rsp_data,
    output enable_write_inst_ram, enable_write_data_ram, enable_read_inst_ram,
    output enable_read_data_ram, enable_read_register, enable_read_floatreg,
    output enable_read_special, rw_address, write_data, dbg_state
  );

  modport master (
    output gpu_run, req_valid, req_write, req_target, req_address, req_wdata, read_data,
    input  req_ready, rsp_valid, rsp_error, rsp_data,
    input  enable_write_inst_ram, enable_write_data_ram, enable_read_inst_ram,
    input  enable_read_data_ram, enable_read_register, enable_read_floatreg,
    input  enable_read_special, rw_address, write_data, dbg_state
  );

endinterface

// File: rtl/gpu_ext_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester not granted last
// wins; the history only moves when a grant is actually taken.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // Grant decode from current requests and last winner.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Last-grant history; reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (take_i && (req_i != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/gpu_ext_arbiter.sv
// Serialises two requesters onto the GPU external access port:
// grant -> issue strobes -> capture read data -> one-cycle response.
module gpu_ext_arbiter
  import gpu_ext_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  gpu_ext_arbiter_if.slave bus
);

  state_t                   state_q;
  logic                     sel_q;
  logic                     write_q;
  logic [2:0]               target_q;
  logic [1:0]               rsp_valid_q;
  logic                     rsp_error_q;
  logic [WORD_WIDTH-1:0]    rsp_data_q;
  logic [ADDRESS_WIDTH-1:0] rw_address_q;
  logic [WORD_WIDTH-1:0]    write_data_q;
  logic [1:0]               gnt;
  logic                     grant_en;
  logic                     gsel;
  logic [1:0]               sel_onehot;
  logic [6:0]               en;

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .req_i  (bus.req_valid),
    .take_i (grant_en),
    .gnt_o  (gnt)
  );

  assign grant_en      = (state_q == ST_IDLE) && !reset && (bus.req_valid != 2'b00);
  assign gsel          = gnt[1];
  assign sel_onehot    = sel_q ? 2'b10 : 2'b01;
  assign bus.req_ready = grant_en ? gnt : 2'b00;

  // Strobe decode; the inst-RAM write waits combinationally on gpu_run so the
  // strobe lands in the very cycle the GPU stops. Reset masks everything.
  always_comb begin
    en = 7'b0;
    if (!reset) begin
      if (write_q) begin
        if (state_q == ST_ISSUE) begin
          if (target_q == TGT_INST_RAM && !bus.gpu_run) en[6] = 1'b1;
          if (target_q == TGT_DATA_RAM)                 en[5] = 1'b1;
        end
      end else if (state_q == ST_ISSUE || state_q == ST_CAPTURE) begin
        case (target_q)
          TGT_INST_RAM:  en[4] = 1'b1;
          TGT_DATA_RAM:  en[3] = 1'b1;
          TGT_INT_REG:   en[2] = 1'b1;
          TGT_FLOAT_REG: en[1] = 1'b1;
          TGT_SPECIAL:   en[0] = 1'b1;
          default:       en    = 7'b0;
        endcase
      end
    end
  end

  // Transaction FSM with registered response and GPU address/data outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= 1'b0;
      write_q      <= 1'b0;
      target_q     <= 3'd0;
      rsp_valid_q  <= 2'b00;
      rsp_error_q  <= 1'b0;
      rsp_data_q   <= '0;
      rw_address_q <= '0;
      write_data_q <= '0;
    end else begin
      rsp_valid_q <= 2'b00;
      rsp_error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_en) begin
            sel_q    <= gsel;
            write_q  <= bus.req_write[gsel];
            target_q <= bus.req_target[gsel];
            if (is_reject(bus.req_write[gsel], bus.req_target[gsel])) begin
              state_q     <= ST_RESPOND;
              rsp_valid_q <= gnt;
              rsp_error_q <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q      <= ST_ISSUE;
              rw_address_q <= bus.req_address[gsel];
              write_data_q <= bus.req_wdata[gsel];
            end
          end
        end
        ST_ISSUE: begin
          if (!write_q) begin
            state_q <= ST_CAPTURE;
          end else if (!(target_q == TGT_INST_RAM && bus.gpu_run)) begin
            state_q     <= ST_RESPOND;
            rsp_valid_q <= sel_onehot;
            rsp_data_q  <= '0;
          end
        end
        ST_CAPTURE: begin
          state_q     <= ST_RESPOND;
          rsp_valid_q <= sel_onehot;
          rsp_data_q  <= bus.read_data;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid             = rsp_valid_q;
  assign bus.rsp_error             = rsp_error_q;
  assign bus.rsp_data              = rsp_data_q;
  assign bus.rw_address            = rw_address_q;
  assign bus.write_data            = write_data_q;
  assign bus.dbg_state             = state_q;
  assign bus.enable_write_inst_ram = en[6];
  assign bus.enable_write_data_ram = en[5];
  assign bus.enable_read_inst_ram  = en[4];
  assign bus.enable_read_data_ram  = en[3];
  assign bus.enable_read_register  = en[2];
  assign bus.enable_read_floatreg  = en[1];
  assign bus.enable_read_special   = en[0];

endmodule

// File: tb/tb_gpu_ext_arbiter.sv
// Bench for gpu_ext_arbiter: directed scenarios plus two random requesters,
// checked by a grant-time reference model and a response scoreboard.
module tb_gpu_ext_arbiter;
  import gpu_ext_arbiter_pkg::*;

  localparam int WW = 32;
  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpu_ext_arbiter_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) bus ();

  gpu_ext_arbiter #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- requester / GPU stimulus signals ----------------
  logic          v [2];
  logic          w [2];
  logic [2:0]    t [2];
  logic [AW-1:0] a [2];
  logic [WW-1:0] d [2];
  logic          gpu_run;
  logic [WW-1:0] gpu_rd;

  assign bus.req_valid   = {v[1], v[0]};
  assign bus.req_write   = {w[1], w[0]};
  assign bus.req_target  = {t[1], t[0]};
  assign bus.req_address = {a[1], a[0]};
  assign bus.req_wdata   = {d[1], d[0]};
  assign bus.gpu_run     = gpu_run;
  assign bus.read_data   = gpu_rd;

  // GPU register/memory contents as seen by reads.
  function automatic logic [WW-1:0] gpu_val(input logic [2:0] tg, input logic [AW-1:0] ad);
    if (tg == 3'd1 && ad == 16'h0010) return 32'hCAFEBABE;
    return ({16'h0, ad} * 32'h9E3779B1) ^ {tg, 29'h0};
  endfunction

  // GPU read port: data follows whichever read enable is raised.
  always @(negedge clk) begin
    if (bus.enable_read_inst_ram)  gpu_rd = gpu_val(3'd0, bus.rw_address);
    if (bus.enable_read_data_ram)  gpu_rd = gpu_val(3'd1, bus.rw_address);
    if (bus.enable_read_register)  gpu_rd = gpu_val(3'd2, bus.rw_address);
    if (bus.enable_read_floatreg)  gpu_rd = gpu_val(3'd3, bus.rw_address);
    if (bus.enable_read_special)   gpu_rd = gpu_val(3'd4, bus.rw_address);
  end

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [WW+1:0] exp_q [$];   // {requester, error, data}
  int            lat_q [$];   // cycle at which rsp_valid is due
  logic          chkd_q[$];   // whether rsp_data is defined for this response
  int            nstb_q[$];   // number of strobe cycles expected

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Which single enable a legal access uses, {wi,wd,ri,rd,rr,rf,rs}; 0 if rejected.
  function automatic logic [6:0] exp_strobe(input logic wr, input logic [2:0] tg);
    if (tg > 3'd4 || (wr && tg > 3'd1)) return 7'b0;
    if (wr) return (tg == 3'd0) ? 7'b1000000 : 7'b0100000;
    return 7'b0010000 >> tg;
  endfunction

  // ---------------- reference model + monitor ----------------
  int            last_g      = 1;
  int            stall_extra = 0;
  logic [6:0]    cur_en      = 7'b0;
  logic [AW-1:0] cur_addr;
  logic [WW-1:0] cur_wd;
  int            strobes     = 0;
  int            mg, mlat, plat;
  logic          merr, mw, pchk;
  logic [2:0]    mt;
  logic [WW-1:0] mdata;
  logic [WW+1:0] pe;
  logic [6:0]    en_now;

  always @(negedge clk) begin
    if (!rst) begin
      en_now = {bus.enable_write_inst_ram, bus.enable_write_data_ram, bus.enable_read_inst_ram,
                bus.enable_read_data_ram, bus.enable_read_register, bus.enable_read_floatreg,
                bus.enable_read_special};
      // grant: predict arbitration winner and the whole response
      if (bus.req_ready !== 2'b00) begin
        check("ready_onehot", $countones(bus.req_ready), 1);
        mg = bus.req_ready[1] ? 1 : 0;
        check("grant_of_valid", bus.req_valid[mg], 1);
        if (bus.req_valid == 2'b11) check("rr_grant", mg, 1 - last_g);
        last_g = mg;
        mw    = w[mg];
        mt    = t[mg];
        merr  = (mt > 3'd4) || (mw && mt > 3'd1);
        mdata = (merr || mw) ? '0 : gpu_val(mt, a[mg]);
        mlat  = merr ? 1 : (mw ? 2 + ((mt == 3'd0) ? stall_extra : 0) : 3);
        exp_q.push_back({mg[0], merr, mdata});
        lat_q.push_back(cyc + mlat);
        chkd_q.push_back(merr || !mw);
        nstb_q.push_back(merr ? 0 : (mw ? 1 : 2));
        cur_en   = exp_strobe(mw, mt);
        cur_addr = a[mg];
        cur_wd   = d[mg];
        strobes  = 0;
      end
      // GPU strobes
      if (en_now != 7'b0) begin
        check("strobe_onehot", $countones(en_now), 1);
        check("strobe_kind", en_now, cur_en);
        check("rw_address", bus.rw_address, cur_addr);
        if (cur_en[6] || cur_en[5]) check("write_data", bus.write_data, cur_wd);
        if (en_now[6]) check("inst_write_while_running", gpu_run, 0);
        strobes++;
      end
      // responses
      if (bus.rsp_valid !== 2'b00) begin
        check("rsp_onehot", $countones(bus.rsp_valid), 1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          pe   = exp_q.pop_front();
          plat = lat_q.pop_front();
          pchk = chkd_q.pop_front();
          check("rsp_requester", bus.rsp_valid, pe[WW+1] ? 2'b10 : 2'b01);
          check("rsp_error", bus.rsp_error, pe[WW]);
          if (pchk) check("rsp_data", bus.rsp_data, pe[WW-1:0]);
          check("rsp_latency", cyc, plat);
          check("strobe_cycles", strobes, nstb_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input logic wr, input logic [2:0] tg,
                       input logic [AW-1:0] ad, input logic [WW-1:0] wd);
    int budget = 0;
    v[i] = 1'b1; w[i] = wr; t[i] = tg; a[i] = ad; d[i] = wd;
    do begin
      @(negedge clk);
      budget++;
    end while (!(bus.req_valid[i] && bus.req_ready[i]) && budget < 200);
    if (budget >= 200) fail_now($sformatf("grant_timeout_req%0d", i));
    @(posedge clk); #1;
    v[i] = 1'b0;
  endtask

  task automatic random_requester(input int i, input int n);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      issue(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            AW'($urandom), $urandom);
    end
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || bus.dbg_state != ST_IDLE) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) fail_now("drain_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_state"},     bus.dbg_state, ST_IDLE);
    check({tag, "_req_ready"}, bus.req_ready, 2'b00);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 2'b00);
    check({tag, "_rsp_error"}, bus.rsp_error, 1'b0);
    check({tag, "_rsp_data"},  bus.rsp_data, 0);
    check({tag, "_enables"},   {bus.enable_write_inst_ram, bus.enable_write_data_ram,
                                bus.enable_read_inst_ram, bus.enable_read_data_ram,
                                bus.enable_read_register, bus.enable_read_floatreg,
                                bus.enable_read_special}, 7'b0);
    check({tag, "_rw_address"}, bus.rw_address, 0);
    check({tag, "_write_data"}, bus.write_data, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int budget;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; w[i] = 1'b0; t[i] = 3'd0; a[i] = '0; d[i] = '0;
    end
    gpu_run = 1'b0;
    gpu_rd  = '0;
    rst     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // read of data RAM 0x0010 returning 0xCAFEBABE
    issue(0, 1'b0, 3'd1, 16'h0010, 32'h0);
    drain();

    // inst RAM write stalled by gpu_run for 5 cycles after the grant
    gpu_run     = 1'b1;
    stall_extra = 5;
    fork
      issue(1, 1'b1, 3'd0, 16'h0004, 32'h00000013);
      begin
        budget = 0;
        do begin
          @(negedge clk);
          budget++;
        end while (!(bus.req_valid[1] && bus.req_ready[1]) && budget < 200);
        repeat (6) @(posedge clk);
        #1 gpu_run = 1'b0;
      end
    join
    drain();
    stall_extra = 0;

    // rejected write and invalid-target read
    issue(0, 1'b1, 3'd3, 16'h1234, 32'h55AA55AA);
    drain();
    issue(0, 1'b0, 3'd6, 16'h4321, 32'h0);
    drain();

    // reset while capturing a read
    issue(0, 1'b0, 3'd2, 16'h0BEE, 32'h0);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (bus.dbg_state != ST_CAPTURE && budget < 20);
    if (budget >= 20) fail_now("capture_timeout");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); lat_q.delete(); chkd_q.delete(); nstb_q.delete();
    last_g = 1;
    cur_en = 7'b0;
    @(negedge clk);
    check("post_reset_state", bus.dbg_state, ST_IDLE);
    check("post_reset_rsp_valid", bus.rsp_valid, 2'b00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_reset_no_rsp", bus.rsp_valid, 2'b00);
    end
    @(posedge clk); #1;

    // both requesters continuously valid: grants must alternate from 0
    fork
      for (int k = 0; k < 3; k++) issue(0, 1'b0, 3'd1, 16'h0100 + 16'(k), 32'h0);
      for (int k = 0; k < 3; k++) issue(1, 1'b1, 3'd1, 16'h0200 + 16'(k), 32'hA0 + 32'(k));
    join
    drain();

    // random traffic from both requesters
    fork
      random_requester(0, 40);
      random_requester(1, 40);
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
